// File: rtl/adder_pkg.sv
// Shared types and helpers for the segmented pipelined add/subtract unit.
// The full-adder cell lives here so every segment is built from the same gate-level equation.
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int nseg_of(input int width, input int seg);
    return width / seg;
  endfunction

  // The split is legal only when the segments tile the word exactly.
  function automatic bit seg_split_ok(input int width, input int seg);
    return (seg > 0) && (width >= seg) && ((width % seg) == 0);
  endfunction

  // Full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

endpackage

// File: rtl/seg_add.sv
// SEG-bit combinational ripple adder built from the full-adder cell.
// c_msb_in exposes the carry into the top bit so the last segment can flag signed overflow.
module seg_add
  import adder_pkg::*;
#(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] s,
  output logic           cout,
  output logic           c_msb_in
);

  logic [SEG:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < SEG; i++) begin
      {c[i+1], s[i]} = full_add(a[i], b[i], c[i]);
    end
  end

  assign cout     = c[SEG];
  assign c_msb_in = c[SEG-1];

endmodule

// File: rtl/seg_pipe_addsub.sv
// WIDTH-bit add/subtract resolved one SEG-bit segment per pipeline stage.
// Handshake: a beat moves only on valid & ready; the whole pipe advances when !out_valid | out_ready.
module seg_pipe_addsub
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  localparam int NSEG = nseg_of(WIDTH, SEG);

  if (!seg_split_ok(WIDTH, SEG)) begin : g_bad_split
    $error("seg_pipe_addsub: WIDTH must be a non-zero multiple of SEG");
  end

  // Stage k register holds the beat after segment k has been resolved;
  // the last stage register is the output register.
  logic             v_q  [NSEG];
  logic [WIDTH-1:0] a_q  [NSEG];
  logic [WIDTH-1:0] b_q  [NSEG];
  logic [WIDTH-1:0] s_q  [NSEG];
  logic             c_q  [NSEG];
  logic             cm_q [NSEG];

  logic [SEG-1:0]   seg_a  [NSEG];
  logic [SEG-1:0]   seg_b  [NSEG];
  logic [SEG-1:0]   seg_s  [NSEG];
  logic             seg_ci [NSEG];
  logic             seg_co [NSEG];
  logic             seg_cm [NSEG];

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  assign out_valid = v_q[NSEG-1];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;

  // Subtraction is a + ~b + ~c_in, so B and the carry are inverted at capture.
  assign b_eff   = b ^ {WIDTH{op == OP_SUB}};
  assign cin_eff = c_in ^ (op == OP_SUB);

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign seg_a[k]  = a[SEG-1:0];
      assign seg_b[k]  = b_eff[SEG-1:0];
      assign seg_ci[k] = cin_eff;
    end else begin : g_rest
      assign seg_a[k]  = a_q[k-1][k*SEG +: SEG];
      assign seg_b[k]  = b_q[k-1][k*SEG +: SEG];
      assign seg_ci[k] = c_q[k-1];
    end

    seg_add #(.SEG(SEG)) u_seg_add (
      .a        (seg_a[k]),
      .b        (seg_b[k]),
      .cin      (seg_ci[k]),
      .s        (seg_s[k]),
      .cout     (seg_co[k]),
      .c_msb_in (seg_cm[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSEG; k++) begin
        v_q[k]  <= 1'b0;
        a_q[k]  <= '0;
        b_q[k]  <= '0;
        s_q[k]  <= '0;
        c_q[k]  <= 1'b0;
        cm_q[k] <= 1'b0;
      end
    end else if (advance) begin
      v_q[0] <= in_valid;
      if (in_valid) begin
        a_q[0]  <= a;
        b_q[0]  <= b_eff;
        s_q[0]  <= WIDTH'(seg_s[0]);
        c_q[0]  <= seg_co[0];
        cm_q[0] <= seg_cm[0];
      end
      // Bubbles shift along with real beats; only the valid bit matters for them.
      for (int k = 1; k < NSEG; k++) begin
        v_q[k]                  <= v_q[k-1];
        a_q[k]                  <= a_q[k-1];
        b_q[k]                  <= b_q[k-1];
        s_q[k]                  <= s_q[k-1];
        s_q[k][k*SEG +: SEG]    <= seg_s[k];
        c_q[k]                  <= seg_co[k];
        cm_q[k]                 <= seg_cm[k];
      end
    end
  end

  assign s     = s_q[NSEG-1];
  assign c_out = c_q[NSEG-1];
  assign ovf   = c_q[NSEG-1] ^ cm_q[NSEG-1];

endmodule

// File: tb/tb_seg_pipe_addsub.sv
// Scoreboard bench for seg_pipe_addsub (WIDTH=16, SEG=4): directed vectors, stall,
// random traffic and a mid-flight asynchronous reset.
module tb_seg_pipe_addsub;
  import adder_pkg::*;

  localparam int W    = 16;
  localparam int SEG  = 4;
  localparam int NSEG = 4;
  localparam int RW   = W + 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  op_e          op = OP_ADD;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] s;
  logic         c_out;
  logic         ovf;

  logic [RW-1:0] exp_q[$];
  time           lat_q[$];
  int            n_cmp = 0;
  int            n_fail = 0;
  int            rst_cnt = 0;
  bit            rnd_done = 1'b0;

  seg_pipe_addsub #(.WIDTH(W), .SEG(SEG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Independent reference: wide add plus the sign rule for overflow.
  function automatic logic [RW-1:0] model(input op_e o, input logic [W-1:0] x,
                                          input logic [W-1:0] y, input logic ci);
    logic [W-1:0] y2;
    logic         ci2;
    logic [W:0]   sum;
    logic         v;
    y2  = (o == OP_SUB) ? ~y : y;
    ci2 = (o == OP_SUB) ? ~ci : ci;
    sum = {1'b0, x} + {1'b0, y2} + {{W{1'b0}}, ci2};
    v   = (x[W-1] == y2[W-1]) && (sum[W-1] != x[W-1]);
    return {sum[W-1:0], sum[W], v};
  endfunction

  // ---------------- driver ----------------
  task automatic send(input op_e o, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic ci, input logic [RW-1:0] req, input bit chk_lat);
    bit ok = 1'b0;
    int tries = 0;
    while (!ok && tries < 200) begin
      @(negedge clk);
      in_valid = 1'b1;
      op = o;
      a = x;
      b = y;
      c_in = ci;
      #1 ok = in_ready;
      @(posedge clk);
      tries++;
    end
    if (ok) begin
      exp_q.push_back(req);
      lat_q.push_back(chk_lat ? $time : 0);
    end else begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 200 cycles");
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 1; i < n; i++) @(negedge clk);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic          prev_hold = 1'b0;
  logic [RW-1:0] prev_out = '0;
  int            seen_rst = 0;

  always @(negedge clk) begin
    logic [RW-1:0] req;
    time           t_acc;
    if (seen_rst != rst_cnt) begin
      prev_hold = 1'b0;
      seen_rst  = rst_cnt;
    end
    if (prev_hold) begin
      check("stall_hold_valid", 32'(out_valid), 32'd1);
      check("stall_hold_data", 32'({s, c_out, ovf}), 32'(prev_out));
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_out: got s=0x%0h with out_valid=1, expected no result", s);
      end else begin
        req   = exp_q.pop_front();
        t_acc = lat_q.pop_front();
        check("result", 32'({s, c_out, ovf}), 32'(req));
        if (t_acc != 0) check("latency", 32'($time - t_acc), 32'((NSEG - 1) * 10 + 5));
      end
    end
    prev_hold = out_valid && !out_ready;
    prev_out  = {s, c_out, ovf};
  end

  // ---------------- stimulus ----------------
  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    check("rst_c_out", 32'(c_out), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_s", 32'(s), 32'h0000);
      check("rst_in_ready", 32'(in_ready), 32'd1);
    end

    // Single ADD with latency check
    send(OP_ADD, 16'h00FF, 16'h0001, 1'b0, {16'h0100, 1'b0, 1'b0}, 1'b1);
    idle(6);

    // Carry / overflow / cross-segment ripple
    send(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, {16'h0000, 1'b1, 1'b0}, 1'b0);
    send(OP_ADD, 16'h7FFF, 16'h0001, 1'b0, {16'h8000, 1'b0, 1'b1}, 1'b0);
    send(OP_ADD, 16'h0FFF, 16'h0001, 1'b0, {16'h1000, 1'b0, 1'b0}, 1'b0);
    send(OP_ADD, 16'hFFFF, 16'hFFFF, 1'b1, {16'hFFFF, 1'b1, 1'b0}, 1'b0);
    idle(6);

    // SUB
    send(OP_SUB, 16'h0005, 16'h0007, 1'b0, {16'hFFFE, 1'b0, 1'b0}, 1'b1);
    idle(6);
    send(OP_SUB, 16'h8000, 16'h0001, 1'b0, {16'h7FFF, 1'b1, 1'b1}, 1'b0);
    send(OP_SUB, 16'h0010, 16'h0003, 1'b1, {16'h000C, 1'b1, 1'b0}, 1'b0);
    idle(6);

    // Backpressure: 6 back-to-back beats, 3-cycle stall after the first result
    fork
      begin
        for (int i = 1; i <= 6; i++)
          send(OP_ADD, W'(i), W'(i), 1'b0, {W'(2 * i), 1'b0, 1'b0}, 1'b0);
        idle(1);
      end
      begin
        t = 0;
        while (!out_valid && t < 50) begin
          @(negedge clk);
          t++;
        end
        check("stall_first_result_seen", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1 out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("no_gap_valid", 32'(out_valid), 32'd1);
        end
      end
    join
    idle(8);

    // Random ops with random gaps and random out_ready
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          op_e          o;
          logic [W-1:0] x, y;
          logic         ci;
          o  = op_e'($urandom_range(0, 1));
          x  = W'($urandom_range(0, 16'hFFFF));
          y  = W'($urandom_range(0, 16'hFFFF));
          ci = 1'($urandom_range(0, 1));
          send(o, x, y, ci, model(o, x, y, ci), 1'b0);
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(1);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("random_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-flight: three beats in the pipe, async pulse between edges
    send(OP_ADD, 16'h0001, 16'h0002, 1'b0, {16'h0003, 1'b0, 1'b0}, 1'b0);
    send(OP_ADD, 16'h0010, 16'h0020, 1'b0, {16'h0030, 1'b0, 1'b0}, 1'b0);
    send(OP_ADD, 16'h0100, 16'h0200, 1'b0, {16'h0300, 1'b0, 1'b0}, 1'b0);
    idle(1);
    @(posedge clk);
    #1 check("pre_reset_valid", 32'(out_valid), 32'd1);
    #1 rst_n = 1'b0;
    exp_q.delete();
    lat_q.delete();
    rst_cnt++;
    #1 check("async_reset_out_valid", 32'(out_valid), 32'd0);
    check("async_reset_in_ready", 32'(in_ready), 32'd1);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_ghost_result", 32'(out_valid), 32'd0);
    end
    send(OP_ADD, 16'h1234, 16'h4321, 1'b1, {16'h5556, 1'b0, 1'b0}, 1'b1);
    idle(8);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
